// File: rtl/code_pack.sv
// Shared types and default sizes for the data-memory dump reader.
// Holds the dump FSM state encoding and the default address/word widths.
package code_pack;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HOLD,
        FINISH
    } dump_state_t;

endpackage

// File: rtl/dmem_reader_rise_detect.sv
// Rising-edge detector: registers a level and flags a low-to-high change.
// Ports: clk, start (async active-high reset), in (level), rise (in && !in_q).
module rise_detect (
    input  logic clk,
    input  logic start,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/dmem_reader.sv
// Dumps a window of data memory after the CPU halts, one beat per word,
// over a valid/ready stream.
// Ports: clk, start (async reset), done (halt level), first_addr, count,
// mem_rd_en/mem_addr/mem_rdata (1-cycle read memory), out_data/out_addr/
// out_valid/out_ready/out_last (output stream), busy, finished (sticky).
module dmem_reader
    import code_pack::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          start,
    input  logic          done,
    input  logic [AW-1:0] first_addr,
    input  logic [AW:0]   count,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          finished
);

    dump_state_t   state;
    logic          trig;
    logic [AW-1:0] base;
    logic [AW:0]   total;
    logic [AW:0]   idx;
    logic [AW-1:0] rd_addr;
    logic          is_last;

    rise_detect u_rise (
        .clk   (clk),
        .start (start),
        .in    (done),
        .rise  (trig)
    );

    // Address of word idx wraps naturally at AW bits.
    always_comb begin
        rd_addr = base + idx[AW-1:0];
        is_last = (idx == total - (AW+1)'(1));
        busy    = (state == READ) || (state == WAIT) || (state == HOLD);
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state     <= IDLE;
            base      <= '0;
            total     <= '0;
            idx       <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            finished  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        base     <= first_addr;
                        total    <= count;
                        idx      <= '0;
                        finished <= 1'b0;
                        if (count == '0) begin
                            state    <= FINISH;
                            finished <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= first_addr;
                        end
                    end
                end
                READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    out_data  <= mem_rdata;
                    out_addr  <= mem_addr;
                    out_valid <= 1'b1;
                    out_last  <= is_last;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= idx + (AW+1)'(1);
                        if (out_last) begin
                            state    <= FINISH;
                            finished <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= rd_addr + AW'(1);
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_reader.sv
// Scoreboard bench for dmem_reader: directed dumps, stall, wrap,
// empty dump, mid-dump abort and retrigger filtering.
module tb_dmem_reader;

    logic       clk = 1'b0;
    logic       start;
    logic       done;
    logic [7:0] first_addr;
    logic [8:0] count;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] out_data;
    logic [7:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       finished;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t sb[$];

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail = 0;
    int beats_seen = 0;
    int rd_cnt = 0;
    int stall_cnt = 0;
    logic stall_en = 1'b0;
    logic prev_rd = 1'b0;

    always #5 clk = ~clk;

    dmem_reader #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .start      (start),
        .done       (done),
        .first_addr (first_addr),
        .count      (count),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .finished   (finished)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            if (!start) rd_cnt <= rd_cnt + 1;
        end
    end

    // Ready driver and monitor in one process so they see the same ready.
    always @(negedge clk) begin
        beat_t e;
        if (stall_en && out_valid && out_addr == 8'h02 && stall_cnt < 4) begin
            out_ready = 1'b0;
            stall_cnt++;
            chk("stall_addr", 32'(out_addr), 32'h02);
            chk("stall_data", 32'(out_data), 32'h00);
            chk("stall_no_rd", 32'(mem_rd_en), 32'h0);
        end else begin
            out_ready = 1'b1;
        end
        if (mem_rd_en && !start) begin
            chk("rd_while_valid", 32'(out_valid), 32'h0);
            chk("rd_single_cycle", 32'(prev_rd), 32'h0);
        end
        prev_rd = mem_rd_en;
        if (out_valid && out_ready && !start) begin
            beats_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_beat_addr", 32'(out_addr), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("beat_addr", 32'(out_addr), 32'(e.a));
                chk("beat_data", 32'(out_data), 32'(e.d));
                chk("beat_last", 32'(out_last), 32'(e.l));
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] d,
                        input logic l);
        beat_t b;
        b.a = a;
        b.d = d;
        b.l = l;
        sb.push_back(b);
    endtask

    // Leaves the bench at the negedge after the trigger edge.
    task automatic trig();
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(finished && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("complete_in_budget", 32'(n < budget), 32'h1);
    endtask

    task automatic push_five();
        push(8'h00, 8'h0F, 1'b0);
        push(8'h01, 8'h0C, 1'b0);
        push(8'h02, 8'h00, 1'b0);
        push(8'h03, 8'h1B, 1'b0);
        push(8'h04, 8'hFA, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int r0;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]   = 8'h0F;
        mem[1]   = 8'h0C;
        mem[2]   = 8'h00;
        mem[3]   = 8'h1B;
        mem[4]   = 8'hFA;
        mem[254] = 8'hA5;
        mem[255] = 8'h5A;
        start = 1'b1;
        done = 1'b0;
        first_addr = 8'h00;
        count = 9'd5;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_addr", 32'(out_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_finished", 32'(finished), 32'h0);
        start = 1'b0;

        // Basic 5-word dump with latency checks.
        push_five();
        trig();
        chk("lat_read_rd_en", 32'(mem_rd_en), 32'h1);
        chk("lat_read_addr", 32'(mem_addr), 32'h0);
        chk("lat_read_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("lat_wait_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("lat_hold_valid", 32'(out_valid), 32'h1);
        wait_done(60);
        chk("t1_finished", 32'(finished), 32'h1);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_sb_empty", 32'(sb.size()), 32'h0);

        // Stall on beat 2.
        stall_en = 1'b1;
        push_five();
        trig();
        wait_done(80);
        stall_en = 1'b0;
        chk("t2_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("t2_sb_empty", 32'(sb.size()), 32'h0);

        // Address wrap.
        first_addr = 8'hFE;
        count = 9'd4;
        push(8'hFE, 8'hA5, 1'b0);
        push(8'hFF, 8'h5A, 1'b0);
        push(8'h00, 8'h0F, 1'b0);
        push(8'h01, 8'h0C, 1'b1);
        trig();
        wait_done(60);
        chk("t3_sb_empty", 32'(sb.size()), 32'h0);

        // Empty dump.
        first_addr = 8'h00;
        count = 9'd0;
        b0 = beats_seen;
        r0 = rd_cnt;
        trig();
        chk("t4_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("t4_finished", 32'(finished), 32'h1);
        repeat (5) @(negedge clk);
        chk("t4_no_rd", 32'(rd_cnt - r0), 32'h0);
        chk("t4_no_beats", 32'(beats_seen - b0), 32'h0);

        // Abort during beat 3, then retrigger from held-high done.
        count = 9'd5;
        push_five();
        trig();
        n = 0;
        while (!(out_valid && out_addr == 8'h02) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_beat3", 32'(n < 40), 32'h1);
        #1 start = 1'b1;
        #1;
        chk("abort_rd_en", 32'(mem_rd_en), 32'h0);
        chk("abort_mem_addr", 32'(mem_addr), 32'h0);
        chk("abort_valid", 32'(out_valid), 32'h0);
        chk("abort_last", 32'(out_last), 32'h0);
        chk("abort_data", 32'(out_data), 32'h0);
        chk("abort_addr", 32'(out_addr), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_finished", 32'(finished), 32'h0);
        sb.delete();
        push_five();
        b0 = beats_seen;
        #1 start = 1'b0;
        @(negedge clk);
        wait_done(60);
        chk("t5_beats", 32'(beats_seen - b0), 32'd5);
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        chk("t5_no_repeat_rd", 32'(rd_cnt - r0), 32'h0);
        chk("t5_idle_busy", 32'(busy), 32'h0);
        chk("t5_sb_empty", 32'(sb.size()), 32'h0);

        // Retoggle done and change inputs mid-dump: ignored.
        count = 9'd3;
        push(8'h00, 8'h0F, 1'b0);
        push(8'h01, 8'h0C, 1'b0);
        push(8'h02, 8'h00, 1'b1);
        b0 = beats_seen;
        trig();
        repeat (2) @(negedge clk);
        first_addr = 8'h10;
        count = 9'd5;
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        wait_done(60);
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        chk("t6_beats", 32'(beats_seen - b0), 32'd3);
        chk("t6_no_retrigger", 32'(rd_cnt - r0), 32'h0);
        chk("t6_sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
